// File: rtl/calc_display.sv
// calc_display: converts a 27-bit binary value to BCD with a serial
// double-dabble engine and drives a multiplexed 8-digit 7-segment display.
// Values above 99_999_999 are shown as eight dashes and flagged on ovf.
module calc_display #(
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [26:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [26:0] MAX_SHOWN = 27'd99_999_999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [26:0]    shreg_q, shreg_d;
    logic [31:0]    bcd_q, bcd_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic           pend_v_q, pend_v_d;
    logic [26:0]    pend_val_q, pend_val_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [31:0]    disp_bcd_q, disp_bcd_d;
    logic           disp_ovf_q, disp_ovf_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [2:0]     scan_q, scan_d;
    logic [7:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;

    // Add 3 to every BCD nibble of 5 or more before the next shift.
    function automatic logic [31:0] dabble_adjust(input logic [31:0] b);
        logic [31:0] r;
        logic [3:0]  nib;
        r = b;
        for (int i = 0; i < 8; i++) begin
            nib = b[4*i +: 4];
            r[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
        return r;
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Conversion FSM, one-deep request holding and display-register update.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        pend_v_d   = pend_v_q;
        pend_val_d = pend_val_q;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = value;
                    bcd_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (load) begin
                    pend_v_d   = 1'b1;
                    pend_val_d = value;
                end else begin
                    pend_v_d   = pend_v_q;
                end
                if (cnt_q == 5'd0) begin
                    ovf_pend_d = (shreg_q > MAX_SHOWN);
                end else begin
                    ovf_pend_d = ovf_pend_q;
                end
                bcd_d   = {dabble_adjust(bcd_q)[30:0], shreg_q[26]};
                shreg_d = {shreg_q[25:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd26) begin
                    state_d = COMMIT;
                end else begin
                    state_d = CONV;
                end
            end
            COMMIT: begin
                disp_bcd_d = ovf_pend_q ? 32'd0 : bcd_q;
                disp_ovf_d = ovf_pend_q;
                done_d     = 1'b1;
                bcd_d      = 32'd0;
                cnt_d      = 5'd0;
                pend_v_d   = 1'b0;
                // A load arriving now is newer than any held request.
                if (load) begin
                    shreg_d = value;
                    state_d = CONV;
                end else if (pend_v_q) begin
                    shreg_d = pend_val_q;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Digit scan prescaler and next an/seg pins computed from next display state.
    always_comb begin
        logic        tick;
        logic [3:0]  nib;
        logic        show;
        logic [7:0]  an_hi;
        logic [6:0]  seg_hi;
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? {PW{1'b0}} : (presc_q + {{(PW-1){1'b0}}, 1'b1});
        scan_d  = tick ? (scan_q + 3'd1) : scan_q;
        nib     = disp_bcd_d[{scan_d, 2'b00} +: 4];
        show    = (scan_d == 3'd0) || ((disp_bcd_d >> {scan_d, 2'b00}) != 32'd0);
        an_hi   = 8'b0000_0001 << scan_d;
        if (disp_ovf_d) begin
            seg_hi = 7'h40;
        end else if (show) begin
            seg_hi = seg7(nib);
        end else begin
            seg_hi = 7'h00;
        end
        an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
        seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

    // State and output registers; reset shows a single "0" on digit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= 27'd0;
            bcd_q      <= 32'd0;
            cnt_q      <= 5'd0;
            ovf_pend_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_val_q <= 27'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            disp_bcd_q <= 32'd0;
            disp_ovf_q <= 1'b0;
            presc_q    <= {PW{1'b0}};
            scan_q     <= 3'd0;
            an_q       <= ACTIVE_LOW ? 8'hFE : 8'h01;
            seg_q      <= ACTIVE_LOW ? 7'h40 : 7'h3F;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            pend_v_q   <= pend_v_d;
            pend_val_q <= pend_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = disp_ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with a scoreboard of expected displayed values.
module tb_calc_display;

    logic        clock = 1'b0;
    logic        reset;
    logic [26:0] value;
    logic        load;
    logic        busy, done, ovf;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy_n, done_n, ovf_n;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [26:0] sb_q[$];

    calc_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut (
        .clock(clock), .reset(reset), .value(value), .load(load),
        .busy(busy), .done(done), .ovf(ovf), .an(an), .seg(seg)
    );

    calc_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_n (
        .clock(clock), .reset(reset), .value(value), .load(load),
        .busy(busy_n), .done(done_n), .ovf(ovf_n), .an(an_n), .seg(seg_n)
    );

    always #5 clock = ~clock;

    // Count done pulses as seen at each rising edge.
    always @(posedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected active-high segments of digit i for displayed value v.
    function automatic logic [6:0] exp_seg(input logic [26:0] v, input int i);
        int unsigned p;
        logic [6:0] s;
        if (v > 27'd99_999_999) return 7'h40;
        p = v;
        for (int k = 0; k < i; k++) p = p / 10;
        if (i != 0 && p == 0) return 7'h00;
        case (p % 10)
            0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
            5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    task automatic pins(input string tag, input logic [7:0] ea, input logic [6:0] es);
        chk({tag, "_an"}, {24'd0, an}, {24'd0, ea});
        chk({tag, "_seg"}, {25'd0, seg}, {25'd0, es});
        chk({tag, "_an_n"}, {24'd0, an_n}, {24'd0, ~ea});
        chk({tag, "_seg_n"}, {25'd0, seg_n}, {25'd0, ~es});
    endtask

    // Index of the active digit, or -1 if an is not one-hot.
    function automatic int active_idx();
        int idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (an == (8'd1 << i)) idx = i;
        end
        return idx;
    endfunction

    task automatic check_active(input string tag, input logic [26:0] v);
        int idx;
        idx = active_idx();
        chk({tag, "_onehot"}, (idx >= 0) ? 32'd1 : 32'd0, 32'd1);
        if (idx >= 0) begin
            chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(v, idx)});
            chk({tag, "_seg_n"}, {25'd0, seg_n}, {25'd0, ~exp_seg(v, idx)});
        end else begin
            chk({tag, "_an_valid"}, {24'd0, an}, 32'd1);
        end
    endtask

    // Scan all eight digits (one per tick) and compare each against the value.
    task automatic check_display(input string tag, input logic [26:0] v);
        logic [7:0] seen = 8'd0;
        int idx;
        for (int j = 0; j < 8; j++) begin
            check_active(tag, v);
            idx = active_idx();
            if (idx >= 0) seen[idx] = 1'b1;
            repeat (4) @(negedge clock);
        end
        chk({tag, "_all_digits"}, {24'd0, seen}, 32'hFF);
        chk({tag, "_ovf"}, {31'd0, ovf}, (v > 27'd99_999_999) ? 32'd1 : 32'd0);
    endtask

    // Drive a one-cycle load; returns at the falling edge after the sampling edge.
    task automatic do_load(input logic [26:0] v, input logic push);
        value = v;
        load  = 1'b1;
        if (push) sb_q.push_back(v);
        @(negedge clock);
        load  = 1'b0;
    endtask

    // Wait (bounded) for done; k counts cycles from the load edge.
    task automatic wait_done(inout int k, output int busy_cycles);
        busy_cycles = 0;
        while (done !== 1'b1 && k < 200) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clock);
            k++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [26:0] v;
        chk({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            chk({tag, "_ovf_at_done"}, {31'd0, ovf}, (v > 27'd99_999_999) ? 32'd1 : 32'd0);
            check_active({tag, "_at_done"}, v);
        end else begin
            chk({tag, "_sb_value"}, 32'd0, 32'd1);
        end
    endtask

    task automatic single(input string tag, input logic [26:0] v);
        int k, bc;
        do_load(v, 1'b1);
        k = 0;
        wait_done(k, bc);
        chk({tag, "_latency"}, k, 32'd28);
        chk({tag, "_busy_cycles"}, bc, 32'd28);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        pop_check(tag);
        @(negedge clock);
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check_display(tag, v);
    endtask

    initial begin
        int k, bc, d0;
        reset = 1'b1;
        load  = 1'b0;
        value = 27'd0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        pins("rst", 8'h01, 7'h3F);

        // Scan sequence from reset release.
        reset = 1'b0;
        @(negedge clock);
        for (int j = 0; j < 8; j++) begin
            pins($sformatf("scan%0d", j), 8'd1 << j, (j == 0) ? 7'h3F : 7'h00);
            repeat (4) @(negedge clock);
        end

        single("v12345678", 27'd12345678);
        single("v907", 27'd907);
        single("v100000000", 27'd100000000);
        single("v5", 27'd5);

        // Three loads: middle one must be overwritten by the last.
        d0 = done_cnt;
        do_load(27'd11, 1'b1);
        k = 0;
        repeat (4) begin @(negedge clock); k++; end
        do_load(27'd22, 1'b0); k++;
        repeat (4) begin @(negedge clock); k++; end
        do_load(27'd33, 1'b1); k++;
        wait_done(k, bc);
        chk("ovr_first_latency", k, 32'd28);
        chk("ovr_busy_stays", {31'd0, busy}, 32'd1);
        pop_check("ovr_first");
        @(negedge clock); k++;
        wait_done(k, bc);
        chk("ovr_second_latency", k, 32'd56);
        pop_check("ovr_second");
        check_display("ovr_final", 27'd33);
        chk("ovr_done_count", done_cnt - d0, 32'd2);

        // Load arriving in the commit cycle starts the next conversion.
        do_load(27'd4321, 1'b1);
        k = 0;
        repeat (27) begin @(negedge clock); k++; end
        do_load(27'd98765432, 1'b1); k++;
        wait_done(k, bc);
        chk("cmt_first_latency", k, 32'd28);
        pop_check("cmt_first");
        @(negedge clock); k++;
        wait_done(k, bc);
        chk("cmt_second_latency", k, 32'd56);
        pop_check("cmt_second");
        check_display("cmt_final", 27'd98765432);

        // Reset mid-conversion aborts it with no done pulse.
        do_load(27'd44, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        pins("abort", 8'h01, 7'h3F);
        d0 = done_cnt;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        check_display("abort_zero", 27'd0);

        single("after_abort", 27'd7);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
